// File: rtl/prbs_ber_ctrl.sv
// BER test controller for the 16-bit inverted-feedback PRBS (taps 15/14/12/3).
// Holds the generator in reset when idle, locks a local replica to rx_bit, then counts bit errors.
module prbs_ber_ctrl #(
    parameter int CNT_W       = 32,
    parameter int ERR_W       = 32,
    parameter int SEED_CYCLES = 2,
    parameter int LOCK_LEN    = 64,
    parameter int ACQ_MAX     = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_bits,
    input  logic             rx_bit,
    output logic             prbs_rst,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int SEQ_MAX = (SEED_CYCLES > 16) ? SEED_CYCLES : 16;
    localparam int SEQ_W   = $clog2(SEQ_MAX);
    localparam int RUN_W   = $clog2(LOCK_LEN + 1);
    localparam int ACQ_W   = $clog2(ACQ_MAX + 1);

    localparam logic [SEQ_W-1:0] SEED_LAST = SEQ_W'(SEED_CYCLES - 1);
    localparam logic [SEQ_W-1:0] FILL_LAST = SEQ_W'(15);
    localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_LEN);
    localparam logic [ACQ_W-1:0] ACQ_C     = ACQ_W'(ACQ_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_FILL, S_ACQ, S_MEAS, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [ACQ_W-1:0] acq_q, acq_d;
    logic [15:0]      h_q, h_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             pred;
    logic             mis;
    logic [RUN_W-1:0] run_inc;
    logic [ACQ_W-1:0] acq_inc;
    logic [CNT_W-1:0] bit_inc;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign pred    = ~h_q[15] ^ h_q[14] ^ h_q[12] ^ h_q[3];
    assign mis     = rx_bit ^ pred;
    assign run_inc = mis ? '0 : run_q + RUN_W'(1);
    assign acq_inc = acq_q + ACQ_W'(1);
    assign bit_inc = bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        run_d     = run_q;
        acq_d     = acq_q;
        h_d       = h_q;
        n_d       = n_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (abort) begin
            state_d   = S_IDLE;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d   = S_SEED;
                        seq_d     = '0;
                        n_d       = n_bits;
                        bit_cnt_d = '0;
                        err_cnt_d = '0;
                        locked_d  = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
                S_SEED: begin
                    if (seq_q == SEED_LAST) begin
                        state_d = S_FILL;
                        seq_d   = '0;
                    end else begin
                        seq_d = seq_q + SEQ_W'(1);
                    end
                end
                S_FILL: begin
                    h_d = {h_q[14:0], rx_bit};
                    if (seq_q == FILL_LAST) begin
                        state_d = S_ACQ;
                        run_d   = '0;
                        acq_d   = '0;
                    end else begin
                        seq_d = seq_q + SEQ_W'(1);
                    end
                end
                S_ACQ: begin
                    h_d   = {h_q[14:0], rx_bit};
                    run_d = run_inc;
                    acq_d = acq_inc;
                    // Lock wins over timeout when both land on the same cycle.
                    if (run_inc == LOCK_C) begin
                        state_d  = S_MEAS;
                        locked_d = 1'b1;
                    end else if (acq_inc == ACQ_C) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end
                end
                S_MEAS: begin
                    // Replica free-runs on its own prediction so a flipped rx bit is counted once.
                    h_d = {h_q[14:0], pred};
                    if (n_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_inc;
                        if (mis) err_cnt_d = sat_inc(err_cnt_q);
                        if (bit_inc == n_q) state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            seq_q     <= '0;
            run_q     <= '0;
            acq_q     <= '0;
            h_q       <= '0;
            n_q       <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            run_q     <= run_d;
            acq_q     <= acq_d;
            h_q       <= h_d;
            n_q       <= n_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign prbs_rst = (state_q == S_IDLE) || (state_q == S_SEED) || (state_q == S_DONE);
    assign busy     = (state_q == S_SEED) || (state_q == S_FILL) ||
                      (state_q == S_ACQ)  || (state_q == S_MEAS);
    assign done     = (state_q == S_DONE);
    assign locked   = locked_q;
    assign timeout  = timeout_q;
    assign bit_cnt  = bit_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prbs_ber_ctrl.sv
// Bench for prbs_ber_ctrl: PRBS generator loopback through 5 register stages,
// with a second instance at ERR_W=4 for saturation.
module tb_prbs_ber_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] n_bits = '0;
    logic        rx_bit;

    logic        prbs_rst, busy, locked, done, timeout;
    logic [31:0] bit_cnt, err_cnt;
    logic        prbs_rst4, busy4, locked4, done4, timeout4;
    logic [31:0] bit_cnt4;
    logic [3:0]  err_cnt4;

    prbs_ber_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_bits(n_bits), .rx_bit(rx_bit),
        .prbs_rst(prbs_rst), .busy(busy), .locked(locked), .done(done), .timeout(timeout),
        .bit_cnt(bit_cnt), .err_cnt(err_cnt)
    );

    prbs_ber_ctrl #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_bits(n_bits), .rx_bit(rx_bit),
        .prbs_rst(prbs_rst4), .busy(busy4), .locked(locked4), .done(done4), .timeout(timeout4),
        .bit_cnt(bit_cnt4), .err_cnt(err_cnt4)
    );

    always #5 clk = ~clk;

    // Link model: generator reset by prbs_rst, output delayed by 5 registers.
    logic [15:0] g    = '0;
    logic [4:0]  pipe = '0;
    always @(posedge clk) begin
        if (prbs_rst) g <= '0;
        else          g <= {g[14:0], ~g[15] ^ g[14] ^ g[12] ^ g[3]};
        pipe <= {pipe[3:0], g[0]};
    end

    logic stuck = 1'b0, flip_pts = 1'b0, flip_all = 1'b0;
    logic flip;
    assign flip   = locked && !done &&
                    (flip_all || (flip_pts && (bit_cnt == 32'd100 || bit_cnt == 32'd101 || bit_cnt == 32'd500)));
    assign rx_bit = stuck ? 1'b0 : (pipe[4] ^ flip);

    typedef struct packed {
        logic        dn;
        logic [31:0] bits;
        logic [31:0] errs;
        logic [3:0]  errs4;
        logic        tmo;
        logic        lck;
    } res_t;

    res_t exp_q[$];
    res_t e, o;
    int total = 0;
    int bad   = 0;

    localparam logic [73:0] RST_VEC = {1'b1, 4'b0000, 32'd0, 32'd0, 1'b1, 4'b0000};
    logic [73:0] rv;

    task automatic pulse_start(input logic [31:0] n);
        @(negedge clk);
        n_bits = n;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_meas_bit(input logic [31:0] target, input int budget);
        int c = 0;
        while (!(locked && !done && bit_cnt == target) && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        #1;
        rv = {prbs_rst, busy, locked, done, timeout, bit_cnt, err_cnt, prbs_rst4, busy4, locked4, done4, timeout4};
        total++;
        if (rv !== RST_VEC) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", rv, RST_VEC);
        end
        total++;
        if ({bit_cnt4, err_cnt4} !== 36'd0) begin
            bad++;
            $display("FAIL reset_dut4_counters got=%h want=0", {bit_cnt4, err_cnt4});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_loopback();
        exp_q.push_back('{1'b1, 32'd1000, 32'd0, 4'd0, 1'b0, 1'b1});
        pulse_start(32'd1000);
        wait_done(6000);
        o = '{done, bit_cnt, err_cnt, err_cnt4, timeout, locked};
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL loopback got dn=%b bits=%0d err=%0d err4=%0d tmo=%b lck=%b want dn=%b bits=%0d err=%0d err4=%0d tmo=%b lck=%b",
                     o.dn, o.bits, o.errs, o.errs4, o.tmo, o.lck, e.dn, e.bits, e.errs, e.errs4, e.tmo, e.lck);
        end
        total++;
        if (prbs_rst !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL loopback_done_ctrl got prbs_rst=%b busy=%b want 1 0", prbs_rst, busy);
        end
    endtask

    task automatic test_errors();
        flip_pts = 1'b1;
        exp_q.push_back('{1'b1, 32'd1000, 32'd3, 4'd3, 1'b0, 1'b1});
        pulse_start(32'd1000);
        wait_done(6000);
        o = '{done, bit_cnt, err_cnt, err_cnt4, timeout, locked};
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL errors3 got dn=%b bits=%0d err=%0d err4=%0d tmo=%b lck=%b want dn=%b bits=%0d err=%0d err4=%0d tmo=%b lck=%b",
                     o.dn, o.bits, o.errs, o.errs4, o.tmo, o.lck, e.dn, e.bits, e.errs, e.errs4, e.tmo, e.lck);
        end
        flip_pts = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc = 1;
        int first_low = 0;
        stuck = 1'b1;
        exp_q.push_back('{1'b1, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0});
        pulse_start(32'd1000);
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (first_low == 0 && prbs_rst == 1'b0) first_low = cyc;
        end
        total++;
        if (first_low != 3) begin
            bad++;
            $display("FAIL timeout_prbs_release got=%0d want=3", first_low);
        end
        total++;
        if (cyc != 2 + 16 + 4096 + 1) begin
            bad++;
            $display("FAIL timeout_latency got=%0d want=%0d", cyc, 2 + 16 + 4096 + 1);
        end
        o = '{done, bit_cnt, err_cnt, err_cnt4, timeout, locked};
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL timeout_result got dn=%b bits=%0d err=%0d err4=%0d tmo=%b lck=%b want dn=%b bits=%0d err=%0d err4=%0d tmo=%b lck=%b",
                     o.dn, o.bits, o.errs, o.errs4, o.tmo, o.lck, e.dn, e.bits, e.errs, e.errs4, e.tmo, e.lck);
        end
        total++;
        if (prbs_rst !== 1'b1) begin
            bad++;
            $display("FAIL timeout_prbs_rst got=%b want=1", prbs_rst);
        end
        stuck = 1'b0;
    endtask

    task automatic test_saturate();
        flip_all = 1'b1;
        exp_q.push_back('{1'b1, 32'd100, 32'd100, 4'd15, 1'b0, 1'b1});
        pulse_start(32'd100);
        wait_done(6000);
        o = '{done, bit_cnt, err_cnt, err_cnt4, timeout, locked};
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL saturate got dn=%b bits=%0d err=%0d err4=%0d tmo=%b lck=%b want dn=%b bits=%0d err=%0d err4=%0d tmo=%b lck=%b",
                     o.dn, o.bits, o.errs, o.errs4, o.tmo, o.lck, e.dn, e.bits, e.errs, e.errs4, e.tmo, e.lck);
        end
        flip_all = 1'b0;
    endtask

    task automatic test_abort();
        pulse_start(32'd1000);
        wait_meas_bit(32'd20, 3000);
        n_bits = 32'd30;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_meas_bit(32'd50, 3000);
        total++;
        if (!(locked === 1'b1 && bit_cnt === 32'd50)) begin
            bad++;
            $display("FAIL start_in_meas_ignored got lck=%b bits=%0d want lck=1 bits=50", locked, bit_cnt);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({busy, done, prbs_rst, locked, timeout, bit_cnt} !== {5'b00100, 32'd50}) begin
            bad++;
            $display("FAIL abort_state got busy=%b done=%b prbs_rst=%b lck=%b tmo=%b bits=%0d want 0 0 1 0 0 50",
                     busy, done, prbs_rst, locked, timeout, bit_cnt);
        end
        repeat (5) @(negedge clk);
        total++;
        if (bit_cnt !== 32'd50 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_hold got bits=%0d busy=%b want 50 0", bit_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back('{1'b1, 32'd10, 32'd0, 4'd0, 1'b0, 1'b1});
        pulse_start(32'd10);
        wait_done(3000);
        o = '{done, bit_cnt, err_cnt, err_cnt4, timeout, locked};
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL b2b_first got dn=%b bits=%0d err=%0d lck=%b want dn=%b bits=%0d err=%0d lck=%b",
                     o.dn, o.bits, o.errs, o.lck, e.dn, e.bits, e.errs, e.lck);
        end
        exp_q.push_back('{1'b1, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1});
        pulse_start(32'd0);
        total++;
        if ({busy, done, prbs_rst, locked, bit_cnt} !== {4'b1010, 32'd0}) begin
            bad++;
            $display("FAIL restart_from_done got busy=%b done=%b prbs_rst=%b lck=%b bits=%0d want 1 0 1 0 0",
                     busy, done, prbs_rst, locked, bit_cnt);
        end
        wait_done(3000);
        o = '{done, bit_cnt, err_cnt, err_cnt4, timeout, locked};
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL nbits_zero got dn=%b bits=%0d err=%0d lck=%b want dn=%b bits=%0d err=%0d lck=%b",
                     o.dn, o.bits, o.errs, o.lck, e.dn, e.bits, e.errs, e.lck);
        end
    endtask

    task automatic test_rst_mid();
        pulse_start(32'd1000);
        repeat (24) @(negedge clk);
        total++;
        if (busy !== 1'b1 || locked !== 1'b0 || prbs_rst !== 1'b0) begin
            bad++;
            $display("FAIL rst_pre_acq got busy=%b lck=%b prbs_rst=%b want 1 0 0", busy, locked, prbs_rst);
        end
        #2 rst = 1'b1;
        #1;
        rv = {prbs_rst, busy, locked, done, timeout, bit_cnt, err_cnt, prbs_rst4, busy4, locked4, done4, timeout4};
        total++;
        if (rv !== RST_VEC) begin
            bad++;
            $display("FAIL rst_mid_acq got=%h want=%h", rv, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start(32'd1000);
        wait_meas_bit(32'd40, 3000);
        #2 rst = 1'b1;
        #1;
        rv = {prbs_rst, busy, locked, done, timeout, bit_cnt, err_cnt, prbs_rst4, busy4, locked4, done4, timeout4};
        total++;
        if (rv !== RST_VEC) begin
            bad++;
            $display("FAIL rst_mid_meas got=%h want=%h", rv, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{1'b1, 32'd200, 32'd0, 4'd0, 1'b0, 1'b1});
        pulse_start(32'd200);
        wait_done(3000);
        o = '{done, bit_cnt, err_cnt, err_cnt4, timeout, locked};
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL post_rst_clean got dn=%b bits=%0d err=%0d lck=%b want dn=%b bits=%0d err=%0d lck=%b",
                     o.dn, o.bits, o.errs, o.lck, e.dn, e.bits, e.errs, e.lck);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_errors();
        test_timeout();
        test_saturate();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/prbs_ber_ctrl.md
# prbs_ber_ctrl

Bit-error-rate test controller for the 16-bit PRBS generator (taps 15/14/12/3, inverted feedback) used on the link. It holds the generator in reset while idle and releases it on command. It self-synchronizes a local replica of the sequence to the received bit stream, then counts bit errors over a programmed number of bits. It sits beside the generator in the link test harness, with its `prbs_rst` output driving the generator's `rst` and `rx_bit` taken from the receiver slicer output.

## Interface
- `CNT_W`, 32: width of `n_bits` and `bit_cnt`.
- `ERR_W`, 32: width of `err_cnt`; `err_cnt` saturates at all-ones.
- `SEED_CYCLES`, 2: cycles spent in SEED (≥1).
- `LOCK_LEN`, 64: consecutive correct predictions required to declare lock.
- `ACQ_MAX`, 4096: ACQ cycles before timeout.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: single-cycle pulse; begins a test. Honoured in IDLE or DONE only.
- `abort`, in, 1: returns to IDLE from any state.
- `n_bits`, in, `CNT_W`: bits to measure; sampled on accepted `start`.
- `rx_bit`, in, 1: received bit, one per cycle.
- `prbs_rst`, out, 1: drives the generator reset.
- `busy`, out, 1: high in SEED, FILL, ACQ and MEAS.
- `locked`, out, 1: high in MEAS; holds its value in DONE.
- `done`, out, 1: high in DONE.
- `timeout`, out, 1: high in DONE when DONE was reached from ACQ.
- `bit_cnt`, out, `CNT_W`: bits measured.
- `err_cnt`, out, `ERR_W`: errors counted.

## Operation
- State machine: IDLE → SEED → FILL → ACQ → MEAS → DONE.
- Exit from ACQ to DONE on timeout.
- Any state except IDLE goes to IDLE on `abort`. `abort` has priority over `start` and over all other transitions.
- `prbs_rst` is decoded from the state register: 1 in IDLE, SEED and DONE; 0 otherwise.
- History register `h[15:0]`.
  - Predicted bit: `p = ~h[15]^h[14]^h[12]^h[3]`.
  - Mismatch: `m = rx_bit ^ p`.
- Transitions and per-state behaviour:
  - IDLE: on `start`, latch `n_bits`, clear `bit_cnt`, `err_cnt`, `timeout` and `locked`, then go to SEED.
  - SEED: stay `SEED_CYCLES` cycles, then go to FILL.
  - FILL: shift `rx_bit` into `h` (`h <= {h[14:0], rx_bit}`) for 16 cycles, then go to ACQ.
  - ACQ: shift `rx_bit` into `h` every cycle.
    - Run counter: increments when `m=0`, clears when `m=1`.
    - When the run counter reaches `LOCK_LEN`, go to MEAS.
    - If the ACQ cycle count reaches `ACQ_MAX` without lock, set `timeout` and go to DONE.
    - Lock takes priority if both conditions occur in the same cycle.
  - MEAS: shift `p` (not `rx_bit`) into `h`, so the replica free-runs and each flipped bit counts exactly once.
    - Each cycle: `bit_cnt += 1`; if `m=1`, `err_cnt += 1`, saturating.
    - When `bit_cnt` reaches the latched `n_bits`, go to DONE.
    - `n_bits = 0` goes to DONE after one MEAS cycle with `bit_cnt = 0`.
  - DONE: outputs and counters hold. `start` restarts exactly as from IDLE.
- `start` in SEED, FILL, ACQ or MEAS is ignored.
- `abort` leaves `bit_cnt` and `err_cnt` holding their values and clears `locked` and `timeout`.

## Timing
- Asynchronous `rst` drives:
  - state to IDLE;
  - `h`, `bit_cnt` and `err_cnt` to 0;
  - `prbs_rst` to 1;
  - `busy`, `locked`, `done` and `timeout` to 0.
- `start` accepted at edge k: state is SEED from edge k. `prbs_rst` stays 1, then falls at edge k+`SEED_CYCLES`.
- FILL lasts exactly 16 cycles. The earliest lock is `LOCK_LEN` cycles after entering ACQ.
- Link latency between generator and `rx_bit` is arbitrary. It is absorbed by FILL/ACQ as long as it is less than `ACQ_MAX − LOCK_LEN`.
- Counters update at the clock edge ending each MEAS cycle. `bit_cnt = n_bits` is visible in the same cycle `done` rises.
- All outputs are registered or state-decoded; there is no combinational path from inputs to outputs.
- Reset asserted mid-test returns to IDLE immediately, with no completion pulse.

## Test plan
- Loopback `rx_bit` = generator output through 5 register stages, `n_bits=1000` → `locked` high, `done` high, `bit_cnt=1000`, `err_cnt=0`, `timeout=0`.
- Same setup, invert `rx_bit` on MEAS bits 100, 101 and 500 → `err_cnt=3` (no error multiplication).
- `rx_bit` stuck at 0 (every prediction mismatches) → DONE after 2+16+4096 cycles, `timeout=1`, `locked=0`, `prbs_rst=1`.
- `ERR_W=4`, lock on clean data, then invert all `rx_bit` in MEAS with `n_bits=100` → `err_cnt=15` (saturated), `bit_cnt=100`.
- `abort` at MEAS bit 50 → IDLE next edge, `bit_cnt=50` held, `prbs_rst=1`. `start` in MEAS is ignored, and `start` in DONE restarts with counters cleared.
- `rst` pulse mid-ACQ and mid-MEAS → all outputs at reset values with no clock edge. The next `start` runs a clean test with `err_cnt=0`.
